// File: rtl/elbeth_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : elbeth_pkg
//  Purpose : Shared types and constants for the data-bus responder:
//            FSM state encoding, bus widths and default window geometry.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package elbeth_pkg;

   localparam int unsigned c_DATA_W          = 32;
   localparam int unsigned c_LANES           = 4;
   localparam logic [31:0] c_DEF_BASE_ADDR   = 32'h0000_1000;
   localparam int unsigned c_DEF_DEPTH_WORDS = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_e;

endpackage : elbeth_pkg
`default_nettype wire

// File: rtl/dbus_storage.sv
`default_nettype none
// ============================================================================
//  Module  : dbus_storage
//  Purpose : Single-port word array with per-byte-lane write enables and a
//            registered read port. Contents are never reset.
//  Ports   : clk      - rising-edge clock
//            addr_i   - word index shared by read and write
//            re_i     - read strobe; captures mem[addr_i] into rdata_o
//            we_i     - byte-lane write enables (one bit per lane)
//            wdata_i  - write data, lane k is wdata_i[8k+7:8k]
//            rdata_o  - registered read data
//  Rev     : 1.0  initial release
// ============================================================================
module dbus_storage
   import elbeth_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = c_DEF_DEPTH_WORDS,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic [AW-1:0]        addr_i,
   input  logic                 re_i,
   input  logic [c_LANES-1:0]   we_i,
   input  logic [c_DATA_W-1:0]  wdata_i,
   output logic [c_DATA_W-1:0]  rdata_o
);

   logic [c_DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [c_DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int k = 0; k < c_LANES; k++) begin
         if (we_i[k]) begin
            mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : dbus_storage
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
//  Module  : dbus_responder
//  Purpose : Fixed-latency memory-window responder for a core data port.
//            A request is latched in IDLE, executed in ACCESS and
//            acknowledged in ACK (accept at edge N, ack during N+2).
//  Ports   : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            enb   - request strobe, held by the initiator until ackb
//            web   - byte-lane write enables, 4'b0000 = read
//            addrb - byte address
//            dinb  - write data
//            doutb - registered read data, held until the next read
//            ackb  - one-cycle completion pulse
//            errb  - error flag, qualified by ackb
//  Rev     : 1.0  initial release
// ============================================================================
module dbus_responder
   import elbeth_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = c_DEF_BASE_ADDR,
   parameter int unsigned DEPTH_WORDS = c_DEF_DEPTH_WORDS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enb,
   input  logic [c_LANES-1:0]   web,
   input  logic [31:0]          addrb,
   input  logic [c_DATA_W-1:0]  dinb,
   output logic [c_DATA_W-1:0]  doutb,
   output logic                 ackb,
   output logic                 errb
);

   localparam int unsigned c_AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] c_SPAN = 32'(DEPTH_WORDS * 4);

   state_e                 state_q, state_d;
   logic [31:0]            addr_q;
   logic [c_LANES-1:0]     web_q;
   logic [c_DATA_W-1:0]    dinb_q;
   logic [c_DATA_W-1:0]    doutb_q;
   logic                   err_q;

   logic                   w_accept;
   logic [31:0]            w_addr_sel;
   logic [31:0]            w_off;
   logic                   w_valid;
   logic [c_AW-1:0]        w_index;
   logic                   w_is_read;
   logic [c_LANES-1:0]     w_we;
   logic [c_DATA_W-1:0]    w_rdata;

   assign w_accept  = (state_q == IDLE) && enb;
   assign w_is_read = (web_q == '0);

   // One decoder serves both phases: in IDLE it indexes the storage with the
   // live address so the registered read is ready by ACCESS; afterwards it
   // decodes the latched address so late input changes have no effect.
   assign w_addr_sel = (state_q == IDLE) ? addrb : addr_q;
   assign w_off      = w_addr_sel - BASE_ADDR;
   // The lower-bound compare rejects wrap-around; once it holds, the
   // unsigned offset cannot wrap and a single upper-bound test suffices.
   assign w_valid    = (w_addr_sel[1:0] == 2'b00) &&
                       (w_addr_sel >= BASE_ADDR) &&
                       (w_off < c_SPAN);
   assign w_index    = w_off[c_AW+1:2];

   // Gating with rst makes a write aborted in ACCESS apply no lanes at all.
   assign w_we = ((state_q == ACCESS) && !w_is_read && w_valid && !rst)
                 ? web_q : '0;

   dbus_storage #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (c_AW)
   ) u_storage (
      .clk     (clk),
      .addr_i  (w_index),
      .re_i    (w_accept),
      .we_i    (w_we),
      .wdata_i (dinb_q),
      .rdata_o (w_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enb) state_d = ACCESS;
         ACCESS:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         doutb_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ACCESS) begin
            err_q <= !w_valid;
            if (w_is_read) begin
               doutb_q <= w_valid ? w_rdata : '0;
            end
         end
      end
   end

   // Request latches need no reset: they are only consumed after an accept.
   always_ff @(posedge clk) begin
      if (!rst && w_accept) begin
         addr_q <= addrb;
         web_q  <= web;
         dinb_q <= dinb;
      end
   end

   assign doutb = doutb_q;
   assign ackb  = (state_q == ACK);
   assign errb  = ackb && err_q;

endmodule : dbus_responder
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dbus_responder
//  Purpose : Directed self-checking bench for dbus_responder
//            (BASE_ADDR 32'h0000_1000, DEPTH_WORDS 64).
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dbus_responder;

   logic        clk;
   logic        rst;
   logic        enb;
   logic [3:0]  web;
   logic [31:0] addrb;
   logic [31:0] dinb;
   logic [31:0] doutb;
   logic        ackb;
   logic        errb;

   int n_vec;
   int n_err;
   logic [31:0] exp_dout;

   dbus_responder #(
      .BASE_ADDR   (32'h0000_1000),
      .DEPTH_WORDS (64)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .enb   (enb),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb),
      .ackb  (ackb),
      .errb  (errb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
         $error("check %s miscompared", tag);
      end
   endtask

   // Starts and ends at a falling edge with the DUT in IDLE.
   // Inputs are scrambled during ACCESS to show they are ignored.
   task automatic do_req(input string tag, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err, input logic [31:0] rd_exp);
      enb = 1'b1; web = w; addrb = a; dinb = d;
      @(negedge clk);
      check({tag, "_ack_access"}, {31'd0, ackb}, 32'd0);
      enb = 1'b0; web = ~w; addrb = ~a; dinb = ~d;
      @(negedge clk);
      if (w == 4'b0000) exp_dout = exp_err ? 32'h0 : rd_exp;
      check({tag, "_ack"},  {31'd0, ackb}, 32'd1);
      check({tag, "_err"},  {31'd0, errb}, {31'd0, exp_err});
      check({tag, "_dout"}, doutb, exp_dout);
      @(negedge clk);
      check({tag, "_ack_done"}, {30'd0, ackb, errb}, 32'd0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; exp_dout = 32'h0;
      rst = 1'b1; enb = 1'b1; web = 4'hF; addrb = 32'h0000_1000; dinb = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rst_ack",  {31'd0, ackb}, 32'd0);
      check("rst_err",  {31'd0, errb}, 32'd0);
      check("rst_dout", doutb, 32'h0);
      rst = 1'b0; enb = 1'b0; web = 4'h0;
      @(negedge clk);
      check("idle_ack", {31'd0, ackb}, 32'd0);

      // write then read back
      do_req("wr0",   4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0);
      do_req("rd0",   4'h0, 32'h0000_1000, 32'h0,         1'b0, 32'hDEAD_BEEF);

      // byte-lane merge
      do_req("wr40",  4'hF, 32'h0000_1040, 32'h1122_3344, 1'b0, 32'h0);
      do_req("wr40b", 4'h5, 32'h0000_1040, 32'hAABB_CCDD, 1'b0, 32'h0);
      do_req("rd40",  4'h0, 32'h0000_1040, 32'h0,         1'b0, 32'h11BB_33DD);

      // last word of the window
      do_req("wrlast", 4'hF, 32'h0000_10FC, 32'h5A5A_5A5A, 1'b0, 32'h0);
      do_req("rdlast", 4'h0, 32'h0000_10FC, 32'h0,         1'b0, 32'h5A5A_5A5A);

      // range and alignment errors
      do_req("rdend",  4'h0, 32'h0000_1100, 32'h0,         1'b1, 32'h0);
      do_req("rdmis",  4'h0, 32'h0000_1002, 32'h0,         1'b1, 32'h0);
      do_req("wrlow",  4'hF, 32'h0000_0FFC, 32'hFFFF_FFFF, 1'b1, 32'h0);
      do_req("wrmis",  4'hF, 32'h0000_10FE, 32'h0000_0000, 1'b1, 32'h0);
      do_req("rdwrap", 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0);
      do_req("rdlst2", 4'h0, 32'h0000_10FC, 32'h0,         1'b0, 32'h5A5A_5A5A);

      // back-to-back with enb held high; accepts N and N+3
      enb = 1'b1; web = 4'h0; addrb = 32'h0000_1000; dinb = 32'h0;
      @(negedge clk);                              // ACCESS of first
      check("b2b_acc1", {31'd0, ackb}, 32'd0);
      web = 4'hF; addrb = 32'h0000_1040; dinb = 32'h0BAD_0BAD;
      @(negedge clk);                              // ACK of first
      check("b2b_ack1",  {31'd0, ackb}, 32'd1);
      check("b2b_dout1", doutb, 32'hDEAD_BEEF);
      web = 4'h0; addrb = 32'h0000_1040; dinb = 32'h0;
      @(negedge clk);                              // IDLE, enb still high
      check("b2b_idle", {31'd0, ackb}, 32'd0);
      @(negedge clk);                              // ACCESS of second
      check("b2b_acc2", {31'd0, ackb}, 32'd0);
      web = 4'hF; addrb = 32'h0000_1000; dinb = 32'h0;
      @(negedge clk);                              // ACK of second
      check("b2b_ack2",  {31'd0, ackb}, 32'd1);
      check("b2b_err2",  {31'd0, errb}, 32'd0);
      check("b2b_dout2", doutb, 32'h11BB_33DD);
      enb = 1'b0; web = 4'h0;
      @(negedge clk);
      check("b2b_done", {31'd0, ackb}, 32'd0);
      exp_dout = 32'h11BB_33DD;
      do_req("rd0b",  4'h0, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF);
      do_req("rd40b", 4'h0, 32'h0000_1040, 32'h0, 1'b0, 32'h11BB_33DD);

      // reset during ACCESS of a write
      do_req("wr80", 4'hF, 32'h0000_1080, 32'h0102_0304, 1'b0, 32'h0);
      enb = 1'b1; web = 4'hF; addrb = 32'h0000_1080; dinb = 32'hF0F0_F0F0;
      @(negedge clk);                              // ACCESS
      rst = 1'b1; enb = 1'b0; web = 4'h0;
      @(negedge clk);
      check("mid_rst_ack",  {31'd0, ackb}, 32'd0);
      check("mid_rst_err",  {31'd0, errb}, 32'd0);
      check("mid_rst_dout", doutb, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_noack", {31'd0, ackb}, 32'd0);
      exp_dout = 32'h0;
      enb = 1'b1; web = 4'h0; addrb = 32'h0000_1080;
      @(negedge clk);
      enb = 1'b0;
      @(negedge clk);
      check("rd80_ack", {31'd0, ackb}, 32'd1);
      check("rd80_atomic", {31'd0, (doutb === 32'h0102_0304) || (doutb === 32'hF0F0_F0F0)}, 32'd1);
      @(negedge clk);
      do_req("rd0_kept", 4'h0, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dbus_responder
`default_nettype wire
